// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier.
//
// Holds the FSM state encoding and small helpers that derive the
// iteration count and the iteration-counter width from the operand width
// and the number of multiplier bits consumed per cycle.
//
// Ports: none (package).
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mulState_e;

  // Number of BUSY iterations for a full-width multiplier operand.
  function automatic int mulIters(input int width, input int bitsPerCycle);
    return width / bitsPerCycle;
  endfunction

  // Counter width able to hold 0..iters-1, never narrower than one bit.
  function automatic int mulCountWidth(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/iterative_mul_step.sv
// One shift-add step of the iterative multiplier.
//
// Adds the partial product mcand * digit to the running accumulator.
// Purely combinational; the caller owns all state and the shifting.
//
// Ports:
//   acc_i      running accumulator (ACC_W bits)
//   mcand_i    multiplicand already shifted to the current digit position
//   digit_i    current multiplier digit (DIGIT_W bits, unsigned)
//   accNext_o  acc_i + mcand_i * digit_i, truncated to ACC_W bits
module iterative_mul_step #(
  parameter int ACC_W   = 64,
  parameter int DIGIT_W = 4
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [ACC_W-1:0]   mcand_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [ACC_W-1:0]   accNext_o
);

  // The digit is zero-extended so the whole expression is evaluated at
  // accumulator width; the final product always fits, so truncation
  // never discards significant bits.
  logic [ACC_W-1:0] digitExt;

  assign digitExt  = ACC_W'(digit_i);
  assign accNext_o = acc_i + (mcand_i * digitExt);

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle unsigned integer multiplier (shift-add, LSB digit first).
//
// Consumes BITS_PER_CYCLE multiplier bits per BUSY cycle and produces the
// exact 2*WIDTH-bit product. One operation is in flight at a time, with a
// valid/ready handshake on both the operand and the result side.
//
// Optional feature: define MUL_EARLY_EXIT_EN to leave BUSY as soon as the
// remaining multiplier bits are all zero. The product value is the same
// either way; only the latency changes.
//
// Ports:
//   clk           clock, all state changes on posedge
//   reset         synchronous, active-high
//   in_valid      operands valid
//   in_ready      block can accept operands (IDLE and not in reset)
//   multiplicand  operand A, unsigned, WIDTH bits
//   multiplier    operand B, unsigned, WIDTH bits
//   out_valid     product valid (registered)
//   out_ready     consumer accepts product
//   product       A*B, unsigned, 2*WIDTH bits
module iterative_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  // WIDTH must be a multiple of BITS_PER_CYCLE.
  localparam int ITERS = mulIters(WIDTH, BITS_PER_CYCLE);
  localparam int CW    = mulCountWidth(ITERS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);

  mulState_e            state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        count_q;
  logic                 outValid_q;

  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   mcand_d;
  logic [WIDTH-1:0]     mplier_d;
  logic [CW-1:0]        count_d;
  logic                 lastIter;

  // Datapath for one BUSY cycle: add the lowest digit's partial product,
  // then move on to the next digit.
  iterative_mul_step #(
    .ACC_W   (2*WIDTH),
    .DIGIT_W (BITS_PER_CYCLE)
  ) u_step (
    .acc_i     (acc_q),
    .mcand_i   (mcand_q),
    .digit_i   (mplier_q[BITS_PER_CYCLE-1:0]),
    .accNext_o (acc_d)
  );

  assign mcand_d  = mcand_q << BITS_PER_CYCLE;
  assign mplier_d = mplier_q >> BITS_PER_CYCLE;
  assign count_d  = count_q + CW'(1);

  // With early exit, a BUSY cycle that leaves no set multiplier bits is
  // also the last one: every remaining partial product would be zero.
`ifdef MUL_EARLY_EXIT_EN
  assign lastIter = (count_q == LAST_COUNT) || (mplier_d == '0);
`else
  assign lastIter = (count_q == LAST_COUNT);
`endif

  // Control and data registers. out_valid is registered and only changes
  // on the BUSY->DONE and DONE->IDLE transitions; acc_q doubles as the
  // product register and keeps the last result until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // in_ready is exactly "IDLE and not in reset", so in_valid alone
          // completes the handshake here.
          if (in_valid) begin
            mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_q <= multiplier;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          count_q  <= count_d;
          if (lastIter) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = outValid_q;
  assign product   = acc_q;

endmodule
